// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole game core.
// Holds the FSM states, mode encodings, timing table and default game lengths.
package wam_pkg;

   typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

   typedef enum logic [1:0] {GmNormal, GmTimed, GmDeath, GmLevel} game_mode_e;

   localparam logic [3:0] MODE_NORMAL = 4'b0001;
   localparam logic [3:0] MODE_TIMED  = 4'b0010;
   localparam logic [3:0] MODE_DEATH  = 4'b0100;
   localparam logic [3:0] MODE_LEVEL  = 4'b1000;

   localparam int unsigned DEF_NORMAL_FLICKS = 25;
   localparam int unsigned DEF_EXT_FLICKS    = 50;

   localparam logic [27:0] TIME_ON_0  = 28'd99_999_999;
   localparam logic [27:0] TIME_ON_1  = 28'd49_999_999;
   localparam logic [27:0] TIME_ON_2  = 28'd49_999_999;
   localparam logic [27:0] TIME_ON_3  = 28'd24_999_999;
   localparam logic [27:0] TIME_BTW_0 = 28'd99_999_999;
   localparam logic [27:0] TIME_BTW_1 = 28'd49_999_999;
   localparam logic [27:0] TIME_BTW_2 = 28'd24_999_999;
   localparam logic [27:0] TIME_BTW_3 = 28'd12_499_999;

   // Anything that is not exactly one of the other modes plays as normal.
   function automatic game_mode_e decode_mode(logic [3:0] m);
      case (m)
         MODE_TIMED: return GmTimed;
         MODE_DEATH: return GmDeath;
         MODE_LEVEL: return GmLevel;
         default:    return GmNormal;
      endcase
   endfunction

   function automatic logic [1:0] diff_to_level(logic [3:0] d);
      case (d)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [27:0] level_on(logic [1:0] lvl);
      case (lvl)
         2'd0:    return TIME_ON_0;
         2'd1:    return TIME_ON_1;
         2'd2:    return TIME_ON_2;
         default: return TIME_ON_3;
      endcase
   endfunction

   function automatic logic [27:0] level_between(logic [1:0] lvl);
      case (lvl)
         2'd0:    return TIME_BTW_0;
         2'd1:    return TIME_BTW_1;
         2'd2:    return TIME_BTW_2;
         default: return TIME_BTW_3;
      endcase
   endfunction

endpackage

// File: rtl/wam_game_core_if.sv
// Control, event and score signals between the game core and its surroundings.
// The master side drives start/config/events; the slave (game core) drives status.
interface wam_game_core_if #(
   parameter int unsigned POS_W = 4,
   parameter int unsigned CNT_W = 7
);
   logic             start;
   logic [3:0]       difficulty;
   logic [3:0]       mode;
   logic             extended;
   logic             mole_up;
   logic             mole_down;
   logic [POS_W-1:0] mole_pos;
   logic             key_valid;
   logic [POS_W-1:0] key;
   logic             run;
   logic [27:0]      time_on;
   logic [27:0]      time_between;
   logic [CNT_W-1:0] hits;
   logic [CNT_W-1:0] misses;
   logic [CNT_W-1:0] flicks;
   logic [6:0]       seconds_left;
   logic [1:0]       level;
   logic             game_over;

   modport master (
      output start, difficulty, mode, extended, mole_up, mole_down, mole_pos, key_valid, key,
      input  run, time_on, time_between, hits, misses, flicks, seconds_left, level, game_over
   );

   modport slave (
      input  start, difficulty, mode, extended, mole_up, mole_down, mole_pos, key_valid, key,
      output run, time_on, time_between, hits, misses, flicks, seconds_left, level, game_over
   );
endinterface

// File: rtl/wam_sec_timer.sv
// Seconds countdown for timed games: a CLK_HZ prescaler feeding a 7-bit down-counter.
// load restarts the prescaler and loads the count; zero flags an exhausted count.
module wam_sec_timer #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [6:0] load_secs,
   input  logic       enable,
   output logic [6:0] seconds_left,
   output logic       zero
);

   localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [6:0]       secs_q, secs_d;

   always_comb begin
      pre_d  = pre_q;
      secs_d = secs_q;
      if (load) begin
         pre_d  = '0;
         secs_d = load_secs;
      end else if (enable) begin
         if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (secs_q != 7'd0) secs_d = secs_q - 7'd1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q  <= '0;
         secs_q <= '0;
      end else begin
         pre_q  <= pre_d;
         secs_q <= secs_d;
      end
   end

   assign seconds_left = secs_q;
   assign zero         = (secs_q == 7'd0);

endmodule

// File: rtl/wam_game_core.sv
// Whack-a-mole game sequencer: runs the IDLE/PLAY/OVER FSM, scores hits and misses
// per flick, tracks level and end conditions for the four game modes.
module wam_game_core
   import wam_pkg::*;
#(
   parameter int unsigned N_MOLES       = 9,
   parameter int unsigned POS_W         = 4,
   parameter int unsigned CNT_W         = 7,
   parameter int unsigned NORMAL_FLICKS = DEF_NORMAL_FLICKS,
   parameter int unsigned EXT_FLICKS    = DEF_EXT_FLICKS,
   parameter int unsigned GAME_SECS     = 60,
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned LEVEL_STEP    = 5
) (
   input logic            clk,
   input logic            reset,
   wam_game_core_if.slave bus
);

   localparam int unsigned STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LEVEL_STEP - 1);
   localparam logic [CNT_W-1:0]  NORMAL_LIM = CNT_W'(NORMAL_FLICKS);
   localparam logic [CNT_W-1:0]  EXT_LIM    = CNT_W'(EXT_FLICKS);

   state_e           state_q, state_d;
   game_mode_e       gmode_q, gmode_d;
   logic             ext_q, ext_d;
   logic             armed_q, armed_d;
   logic [POS_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] hits_q, hits_d;
   logic [CNT_W-1:0] misses_q, misses_d;
   logic [CNT_W-1:0] flicks_q, flicks_d;
   logic [1:0]       level_q, level_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [27:0]      time_on_q, time_between_q;

   logic             hit_ev, miss_key, miss_down, up_ok;
   logic             timer_load, timer_en, sec_zero;
   logic [6:0]       load_secs, seconds_left;
   logic [CNT_W-1:0] limit;
   game_mode_e       start_mode;

   function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign start_mode = decode_mode(bus.mode);
   assign limit      = ext_q ? EXT_LIM : NORMAL_LIM;
   assign load_secs  = (start_mode == GmTimed) ? 7'(GAME_SECS) : 7'd0;

   always_comb begin
      state_d    = state_q;
      gmode_d    = gmode_q;
      ext_d      = ext_q;
      armed_d    = armed_q;
      target_d   = target_q;
      hits_d     = hits_q;
      misses_d   = misses_q;
      flicks_d   = flicks_q;
      level_d    = level_q;
      step_d     = step_q;
      timer_load = 1'b0;
      hit_ev     = 1'b0;
      miss_key   = 1'b0;
      miss_down  = 1'b0;
      up_ok      = 1'b0;

      if (bus.start) begin
         state_d    = StPlay;
         gmode_d    = start_mode;
         ext_d      = bus.extended;
         armed_d    = 1'b0;
         hits_d     = '0;
         misses_d   = '0;
         flicks_d   = '0;
         step_d     = '0;
         level_d    = (start_mode == GmLevel) ? 2'd0 : diff_to_level(bus.difficulty);
         timer_load = 1'b1;
      end else if (state_q == StPlay) begin
         hit_ev    = bus.key_valid && armed_q && (bus.key == target_q);
         miss_key  = bus.key_valid && !hit_ev;
         // A wrong key leaves the mole armed, so its later mole_down is a second miss.
         miss_down = bus.mole_down && armed_q && !hit_ev;
         up_ok     = bus.mole_up && (32'(bus.mole_pos) < N_MOLES);

         if (hit_ev) begin
            hits_d  = sat_inc(hits_q);
            armed_d = 1'b0;
            if (gmode_q == GmLevel) begin
               if (step_q == STEP_MAX) begin
                  step_d = '0;
                  if (level_q != 2'd3) level_d = level_q + 2'd1;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         if (miss_key) misses_d = sat_inc(misses_d);
         if (miss_down) begin
            misses_d = sat_inc(misses_d);
            armed_d  = 1'b0;
         end
         if (up_ok) begin
            target_d = bus.mole_pos;
            armed_d  = 1'b1;
            flicks_d = sat_inc(flicks_q);
         end

         case (gmode_q)
            GmTimed: if (sec_zero) state_d = StOver;
            GmDeath: if (miss_key || miss_down) state_d = StOver;
            default: if ((flicks_d == limit) && !armed_d) state_d = StOver;
         endcase
      end
   end

   assign timer_en = (state_q == StPlay) && (gmode_q == GmTimed);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         gmode_q        <= GmNormal;
         ext_q          <= 1'b0;
         armed_q        <= 1'b0;
         target_q       <= '0;
         hits_q         <= '0;
         misses_q       <= '0;
         flicks_q       <= '0;
         level_q        <= 2'd0;
         step_q         <= '0;
         time_on_q      <= '0;
         time_between_q <= '0;
      end else begin
         state_q        <= state_d;
         gmode_q        <= gmode_d;
         ext_q          <= ext_d;
         armed_q        <= armed_d;
         target_q       <= target_d;
         hits_q         <= hits_d;
         misses_q       <= misses_d;
         flicks_q       <= flicks_d;
         level_q        <= level_d;
         step_q         <= step_d;
         time_on_q      <= level_on(level_q);
         time_between_q <= level_between(level_q);
      end
   end

   wam_sec_timer #(
      .CLK_HZ(CLK_HZ)
   ) u_sec_timer (
      .clk         (clk),
      .reset       (reset),
      .load        (timer_load),
      .load_secs   (load_secs),
      .enable      (timer_en),
      .seconds_left(seconds_left),
      .zero        (sec_zero)
   );

   assign bus.run          = (state_q == StPlay);
   assign bus.game_over    = (state_q == StOver);
   assign bus.hits         = hits_q;
   assign bus.misses       = misses_q;
   assign bus.flicks       = flicks_q;
   assign bus.level        = level_q;
   assign bus.seconds_left = seconds_left;
   assign bus.time_on      = time_on_q;
   assign bus.time_between = time_between_q;

endmodule

// File: tb/tb_wam_game_core.sv
// Directed self-checking bench for wam_game_core with small game parameters.
module tb_wam_game_core;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   wam_game_core_if #(.POS_W(4), .CNT_W(7)) bus ();

   wam_game_core #(
      .N_MOLES      (9),
      .POS_W        (4),
      .CNT_W        (7),
      .NORMAL_FLICKS(3),
      .EXT_FLICKS   (8),
      .GAME_SECS    (3),
      .CLK_HZ       (10),
      .LEVEL_STEP   (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game(input logic [3:0] m, input logic [3:0] d, input logic e);
      bus.start = 1'b1; bus.mode = m; bus.difficulty = d; bus.extended = e;
      tick();
      bus.start = 1'b0; bus.mode = 4'b0000; bus.difficulty = 4'b0000; bus.extended = 1'b0;
   endtask

   task automatic up(input logic [3:0] p);
      bus.mole_up = 1'b1; bus.mole_pos = p;
      tick();
      bus.mole_up = 1'b0;
   endtask

   task automatic press(input logic [3:0] k);
      bus.key_valid = 1'b1; bus.key = k;
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic press_down(input logic [3:0] k);
      bus.key_valid = 1'b1; bus.key = k; bus.mole_down = 1'b1;
      tick();
      bus.key_valid = 1'b0; bus.mole_down = 1'b0;
   endtask

   task automatic down();
      bus.mole_down = 1'b1;
      tick();
      bus.mole_down = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      checks++; if (bus.run !== 1'b0) begin errors++; $display("FAIL reset_run: got %0b want 0", bus.run); end
      checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %0b want 0", bus.game_over); end
      checks++; if (bus.hits !== 7'd0 || bus.misses !== 7'd0 || bus.flicks !== 7'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", bus.hits, bus.misses, bus.flicks); end
      checks++; if (bus.seconds_left !== 7'd0 || bus.level !== 2'd0) begin
         errors++; $display("FAIL reset_secs_level: got %0d/%0d want 0/0", bus.seconds_left, bus.level); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_normal();
      start_game(4'b0001, 4'b0001, 1'b0);
      checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL normal_run: got %0b want 1", bus.run); end
      for (int i = 0; i < 3; i++) begin
         up(4'd4);
         press(4'd4);
         if (i < 2) begin
            checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL normal_early_over: flick %0d got 1 want 0", i); end
         end
      end
      checks++; if (bus.hits !== 7'd3 || bus.misses !== 7'd0) begin
         errors++; $display("FAIL normal_score: got %0d/%0d want 3/0", bus.hits, bus.misses); end
      checks++; if (bus.game_over !== 1'b1 || bus.run !== 1'b0) begin
         errors++; $display("FAIL normal_over: got over=%0b run=%0b want 1/0", bus.game_over, bus.run); end
      checks++; if (bus.time_on !== 28'd99_999_999) begin
         errors++; $display("FAIL normal_time_on: got %0d want 99999999", bus.time_on); end
   endtask

   task automatic test_miss();
      start_game(4'b0001, 4'b0001, 1'b1);
      up(4'd2);
      press(4'd5);
      checks++; if (bus.misses !== 7'd1) begin errors++; $display("FAIL miss_wrong_key: got %0d want 1", bus.misses); end
      down();
      checks++; if (bus.misses !== 7'd2 || bus.hits !== 7'd0) begin
         errors++; $display("FAIL miss_down: got %0d/%0d want 2/0", bus.misses, bus.hits); end
      press(4'd3);
      checks++; if (bus.misses !== 7'd3) begin errors++; $display("FAIL miss_unarmed: got %0d want 3", bus.misses); end
      checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL miss_over: got 1 want 0"); end
   endtask

   task automatic test_simultaneous();
      start_game(4'b0001, 4'b0001, 1'b1);
      up(4'd6);
      press_down(4'd6);
      checks++; if (bus.hits !== 7'd1 || bus.misses !== 7'd0) begin
         errors++; $display("FAIL simul_hit: got %0d/%0d want 1/0", bus.hits, bus.misses); end
      up(4'd9);
      checks++; if (bus.flicks !== 7'd1) begin errors++; $display("FAIL simul_badpos: got %0d want 1", bus.flicks); end
      press(4'd6);
      checks++; if (bus.misses !== 7'd1) begin errors++; $display("FAIL simul_not_rearmed: got %0d want 1", bus.misses); end
   endtask

   task automatic test_timed();
      start_game(4'b0010, 4'b0100, 1'b0);
      checks++; if (bus.seconds_left !== 7'd3 || bus.level !== 2'd2) begin
         errors++; $display("FAIL timed_load: got %0d/%0d want 3/2", bus.seconds_left, bus.level); end
      for (int i = 0; i < 4; i++) begin
         up(4'(i));
         press(4'(i));
      end
      checks++; if (bus.hits !== 7'd4 || bus.game_over !== 1'b0) begin
         errors++; $display("FAIL timed_no_limit: got hits=%0d over=%0b want 4/0", bus.hits, bus.game_over); end
      tick();
      checks++; if (bus.seconds_left !== 7'd3) begin errors++; $display("FAIL timed_c9: got %0d want 3", bus.seconds_left); end
      tick();
      checks++; if (bus.seconds_left !== 7'd2) begin errors++; $display("FAIL timed_c10: got %0d want 2", bus.seconds_left); end
      repeat (10) tick();
      checks++; if (bus.seconds_left !== 7'd1) begin errors++; $display("FAIL timed_c20: got %0d want 1", bus.seconds_left); end
      repeat (10) tick();
      checks++; if (bus.seconds_left !== 7'd0) begin errors++; $display("FAIL timed_c30: got %0d want 0", bus.seconds_left); end
      tick();
      checks++; if (bus.game_over !== 1'b1 || bus.run !== 1'b0) begin
         errors++; $display("FAIL timed_over: got over=%0b run=%0b want 1/0", bus.game_over, bus.run); end
      up(4'd1);
      press(4'd1);
      checks++; if (bus.hits !== 7'd4 || bus.flicks !== 7'd4) begin
         errors++; $display("FAIL timed_frozen: got %0d/%0d want 4/4", bus.hits, bus.flicks); end
   endtask

   task automatic test_deathmatch();
      start_game(4'b0100, 4'b0001, 1'b1);
      up(4'd3);
      press(4'd3);
      checks++; if (bus.hits !== 7'd1 || bus.game_over !== 1'b0) begin
         errors++; $display("FAIL death_hit: got hits=%0d over=%0b want 1/0", bus.hits, bus.game_over); end
      up(4'd5);
      press(4'd7);
      checks++; if (bus.misses !== 7'd1 || bus.game_over !== 1'b1) begin
         errors++; $display("FAIL death_miss: got misses=%0d over=%0b want 1/1", bus.misses, bus.game_over); end
      press(4'd5);
      checks++; if (bus.misses !== 7'd1 || bus.hits !== 7'd1) begin
         errors++; $display("FAIL death_frozen: got %0d/%0d want 1/1", bus.hits, bus.misses); end
   endtask

   task automatic test_level();
      start_game(4'b1000, 4'b1000, 1'b1);
      checks++; if (bus.level !== 2'd0) begin errors++; $display("FAIL level_start: got %0d want 0", bus.level); end
      for (int i = 0; i < 4; i++) begin
         up(4'(i));
         press(4'(i));
         if (i == 1) begin
            checks++; if (bus.level !== 2'd1) begin errors++; $display("FAIL level_hit2: got %0d want 1", bus.level); end
         end
      end
      checks++; if (bus.level !== 2'd2) begin errors++; $display("FAIL level_hit4: got %0d want 2", bus.level); end
      checks++; if (bus.time_between !== 28'd49_999_999) begin
         errors++; $display("FAIL level_btw_lag: got %0d want 49999999", bus.time_between); end
      tick();
      checks++; if (bus.time_between !== 28'd24_999_999 || bus.time_on !== 28'd49_999_999) begin
         errors++; $display("FAIL level_times: got %0d/%0d want 49999999/24999999", bus.time_on, bus.time_between); end
      checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL level_over: got 1 want 0"); end
   endtask

   task automatic test_reset_mid();
      start_game(4'b0001, 4'b0001, 1'b1);
      for (int i = 0; i < 5; i++) begin
         up(4'd4);
         press(4'd4);
      end
      checks++; if (bus.hits !== 7'd5) begin errors++; $display("FAIL mid_hits: got %0d want 5", bus.hits); end
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.run !== 1'b0 || bus.hits !== 7'd0 || bus.flicks !== 7'd0 || bus.game_over !== 1'b0) begin
         errors++; $display("FAIL mid_async: got run=%0b hits=%0d flicks=%0d over=%0b want 0",
                            bus.run, bus.hits, bus.flicks, bus.game_over); end
      checks++; if (bus.time_on !== 28'd0 || bus.time_between !== 28'd0 || bus.level !== 2'd0) begin
         errors++; $display("FAIL mid_async_times: got %0d/%0d/%0d want 0", bus.time_on, bus.time_between, bus.level); end
      @(posedge clk);
      #2 reset = 1'b1;
      tick();
      press(4'd4);
      checks++; if (bus.misses !== 7'd0 || bus.run !== 1'b0) begin
         errors++; $display("FAIL idle_ignore: got misses=%0d run=%0b want 0/0", bus.misses, bus.run); end
      start_game(4'b0001, 4'b0011, 1'b0);
      checks++; if (bus.run !== 1'b1 || bus.level !== 2'd1 || bus.hits !== 7'd0) begin
         errors++; $display("FAIL restart: got run=%0b level=%0d hits=%0d want 1/1/0", bus.run, bus.level, bus.hits); end
      up(4'd0);
      press(4'd0);
      checks++; if (bus.hits !== 7'd1 || bus.time_on !== 28'd49_999_999) begin
         errors++; $display("FAIL restart_hit: got hits=%0d on=%0d want 1/49999999", bus.hits, bus.time_on); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bus.start = 1'b0; bus.difficulty = 4'b0000; bus.mode = 4'b0000; bus.extended = 1'b0;
      bus.mole_up = 1'b0; bus.mole_down = 1'b0; bus.mole_pos = 4'd0;
      bus.key_valid = 1'b0; bus.key = 4'd0;
      test_reset();
      test_normal();
      test_miss();
      test_simultaneous();
      test_timed();
      test_deathmatch();
      test_level();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wam_game_core.md
Name: wam_game_core

Overview:
- Parametrised game sequencer and scorekeeper for whack-a-mole; sits between light_controller, keypad_controller and the HEX/LED display logic.
- Owns the game FSM and the four game modes: normal, timed, deathmatch and level continuity.
- Drives the on/between timing to the light controller and scores hits and misses per flick.
- Scales to N_MOLES lights and configurable game length, timed duration and clock rate.

Parameters:
- N_MOLES, 9, number of lights/keys; positions 0..N_MOLES-1.
- POS_W, 4, width of position buses; must satisfy 2^POS_W >= N_MOLES.
- CNT_W, 7, width of the hit, miss and flick counters.
- NORMAL_FLICKS, 25, game length in flicks when extended=0.
- EXT_FLICKS, 50, game length in flicks when extended=1.
- GAME_SECS, 60, timed-mode duration in seconds.
- CLK_HZ, 50_000_000, clock cycles per second; drives the timed-mode prescaler.
- LEVEL_STEP, 5, hits per level advance in level-continuity mode.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle start/restart pulse.
- difficulty, in, 4, one-hot level select (SW[3:0]).
- mode, in, 4, one-hot mode: 0001 normal, 0010 timed, 0100 deathmatch, 1000 level continuity.
- extended, in, 1, selects EXT_FLICKS instead of NORMAL_FLICKS.
- mole_up, in, 1, pulse: a light turned on at mole_pos.
- mole_down, in, 1, pulse: the current light turned off.
- mole_pos, in, POS_W, position of the light.
- key_valid, in, 1, pulse: keypad press is valid.
- key, in, POS_W, position of the pressed key.
- run, out, 1, high while in PLAY; drives light_controller start.
- time_on, out, 28, light-on duration in cycles minus 1.
- time_between, out, 28, gap between flicks in cycles minus 1.
- hits, out, CNT_W, hit count.
- misses, out, CNT_W, miss count.
- flicks, out, CNT_W, number of lights shown.
- seconds_left, out, 7, remaining seconds in timed mode; 0 otherwise.
- level, out, 2, current level index 0..3.
- game_over, out, 1, high in OVER.

Behaviour:
- Reset (async, low): state=IDLE. run, hits, misses, flicks, seconds_left, level, game_over, armed and prescaler all 0. target=0.
- FSM states: IDLE, PLAY, OVER.
- start in any state → PLAY next cycle:
  - counters cleared, armed=0, prescaler=0;
  - seconds_left=GAME_SECS if mode==0010, else 0;
  - level=0 in mode 1000, else the index of difficulty.
- mode, difficulty and extended are sampled only on start; they are held through the game.
- Timing table by level index:
  - 0: on=99_999_999, between=99_999_999.
  - 1: on=49_999_999, between=49_999_999.
  - 2: on=49_999_999, between=24_999_999.
  - 3: on=24_999_999, between=12_499_999.
  - A non-one-hot difficulty maps to index 1.
  - Outputs are registered and update the cycle after level changes.
- PLAY, events in priority order within one cycle:
  1. key_valid. If armed and key==target: hits+1, armed=0. Otherwise (wrong key or not armed): misses+1.
  2. mole_down while armed (and not already resolved by a hit this cycle): misses+1, armed=0.
  3. mole_up: target=mole_pos, armed=1, flicks+1. A mole_pos >= N_MOLES is ignored entirely.
- A key press and mole_down in the same cycle on the correct target count as a hit only.
- Counters saturate at 2^CNT_W-1.
- Level continuity mode:
  - After every LEVEL_STEP hits, level+1, saturating at 3.
  - Takes effect from the next mole_up.
- Timed mode:
  - The prescaler counts 0..CLK_HZ-1; on wrap, seconds_left decrements.
  - seconds_left==0 → OVER.
  - The flick limit is ignored.
- End conditions, all → OVER:
  - modes 0001 and 1000: flicks==limit and armed==0 after the cycle's events;
  - mode 0100: any miss increment;
  - mode 0010: timeout.
  - Non-one-hot mode behaves as normal.
- OVER: run=0, game_over=1. Counters are frozen and inputs ignored until start.
- IDLE: run=0. Events are ignored.

Decomposition:
- Shared package wam_pkg holds:
  - state encodings IDLE/PLAY/OVER;
  - mode one-hot constants;
  - the 4-entry timing table constants;
  - NORMAL_FLICKS and EXT_FLICKS defaults.
- One natural sub-module: wam_sec_timer. It contains the prescaler plus seconds_left down-counter, with load/enable and a zero flag.

Test Plan:
- Normal game, flick limit, all hits: mode=0001, extended=0, NORMAL_FLICKS=3. Start, then 3× (mole_up pos 4, key 4). Expect hits=3, misses=0, game_over=1 one cycle after the 3rd hit, run=0.
- Miss paths: mole_up pos 2, key 5, then mole_down. Expect misses=2, hits=0. Then a key press with nothing armed gives misses=3.
- Simultaneous events: a key on the correct target and mole_down in the same cycle give hits+1, misses unchanged. mole_up pos 9 (N_MOLES=9) leaves flicks unchanged.
- Timed mode: CLK_HZ=10, GAME_SECS=3, mode=0010. Expect seconds_left 3→2→1→0 at 10-cycle intervals, then OVER; hits are accepted until then.
- Deathmatch and level continuity:
  - mode=0100: the first miss gives OVER with misses=1.
  - mode=1000, LEVEL_STEP=2: hits 2 and 4 give level 1 then 2. time_between becomes 24_999_999 at level 2.
- Reset mid-game: assert reset low during PLAY with hits=5. Expect all outputs 0 immediately (async), state IDLE. Start afterwards begins a clean game.
